seq_det_param: RTL
==================

// Module: seq_det_param
// PURPOSE
//   Parametrised serial bit-pattern detector; next generation of the fixed 1010 Mealy detector.
//   Pattern, length, overlap mode and output style (Mealy/Moore) are set by parameters.
//   Adds a qualifying enable, a synchronous clear and a saturating match counter.
//   Sits on a 1-bit serial stream in the control path; z feeds event logic, match_cnt is read by status.
// PARAMETERS
//   LEN      4        pattern length in bits; legal range 2..32
//   PATTERN  4'b1010  target pattern, LEN bits; PATTERN[LEN-1] is compared to the oldest bit
//   OVERLAP  0        0 = non-overlapping (history cleared on match), 1 = overlapping
//   MOORE    0        0 = Mealy (z combinational, same cycle as last bit), 1 = Moore (z registered)
//   CNT_W    8        width of match_cnt
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-low reset
//   en         in   1      x is sampled only on cycles where en=1
//   clr        in   1      synchronous clear of history, z and counter
//   x          in   1      serial input bit
//   z          out  1      match pulse
//   match_cnt  out  CNT_W  number of matches since reset/clr, saturating
// BEHAVIOUR
//   - Reset (rst=0, async): hist=0, fill=0, z=0 (Moore reg), match_cnt=0. Mealy z=0 while rst=0.
//   - State: hist[LEN-2:0] = last LEN-1 accepted bits, newest in bit 0.
//     fill = count of valid bits in hist, 0..LEN-1.
//   - match = en & !clr & (fill==LEN-1) & ({hist,x}==PATTERN).
//   - Accepted bit (en=1, clr=0) at posedge:
//     - hist <= {hist[LEN-3:0],x};
//     - if match & !OVERLAP: fill <= 0, so the next match needs LEN fresh bits;
//     - else fill <= min(fill+1, LEN-1).
//   - en=0: hist, fill and match_cnt hold. Mealy z=0; Moore z <= 0 at the next edge.
//   - Mealy (MOORE=0): z = match, combinational from x/en/clr.
//     High in the same cycle as the final pattern bit, for one cycle per match.
//   - Moore (MOORE=1): z <= match at each posedge.
//     High for exactly the one cycle after the final bit is sampled.
//     Back-to-back overlapping matches give consecutive z=1 cycles.
//   - match_cnt <= match_cnt+1 on each match; holds at 2^CNT_W-1 (no wrap).
//   - clr=1 at posedge: hist=0, fill=0, match_cnt=0, Moore z=0.
//     clr overrides en; a pattern completing in the same cycle is neither flagged nor counted.
//   - A partial pattern spanning an en=0 gap still matches; gaps are transparent.
//   - Reset asserted mid-pattern discards all history; detection restarts after release.
//   - Match uses only the rst/clr-cleared state; no match is possible until LEN bits are accepted.
// TESTING
//   1 LEN=4,PATTERN=1010,OVERLAP=0,MOORE=0; en=1, x=1,1,0,0,1,0,1,0,1,1
//     -> z=1 only on 8th bit (x=0), match_cnt=1.
//   2 Same config, x=1,0,1,0,1,0 -> z=1 on bit 4 only; match_cnt=1.
//     With OVERLAP=1 -> z=1 on bits 4 and 6; match_cnt=2.
//   3 MOORE=1,OVERLAP=1, x=1,0,1,0,1,0 -> z high the cycle after bit 4 and after bit 6.
//     Never high in the same cycle as the bit.
//   4 Feed 1,0,1; drop en for 3 cycles with x toggling; then en=1, x=0 -> z=1, match_cnt=1.
//   5 CNT_W=2, OVERLAP=1, repeat 1,0 x8 -> match_cnt rises 1,2,3 then stays 3.
//     Then clr=1 on the cycle of a completing 0 -> z=0, match_cnt=0.
//   6 Assert rst=0 asynchronously after 1,0,1 (mid-clock) -> z, match_cnt=0 immediately.
//     After release, x=0 alone gives no match; full 1,0,1,0 gives z=1.

Source files
------------

// File: rtl/seq_det_param.sv
// -----------------------------------------------------------------------------
// seq_det_param
//   Parameterised serial bit-pattern detector on a 1-bit control-path stream.
//   It keeps the last LEN-1 accepted bits and compares them, together with the
//   current input bit, against PATTERN. The pattern, its length, overlap mode
//   and output style (Mealy or Moore) are all parameters. The block also has a
//   qualifying enable, a synchronous clear and a saturating match counter.
//
// Parameters
//   LEN      pattern length in bits (2..32)
//   PATTERN  target pattern; PATTERN[LEN-1] is compared to the oldest bit
//   OVERLAP  0 = history restarts after a match, 1 = overlapping matches
//   MOORE    0 = z is combinational (same cycle as the last bit),
//            1 = z is registered (the cycle after the last bit)
//   CNT_W    width of match_cnt
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active low
//   en         in   x is sampled only when en=1
//   clr        in   synchronous clear of history, counter and Moore z
//   x          in   serial input bit
//   z          out  match pulse
//   match_cnt  out  matches since reset/clr, saturating at all-ones
// -----------------------------------------------------------------------------
module seq_det_param #(
   parameter int unsigned          LEN     = 4,
   parameter logic [LEN-1:0]       PATTERN = 4'b1010,
   parameter bit                   OVERLAP = 1'b0,
   parameter bit                   MOORE   = 1'b0,
   parameter int unsigned          CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             x,
   output logic             z,
   output logic [CNT_W-1:0] match_cnt
);

   // fill counts 0..LEN-1, so $clog2(LEN) bits are always enough.
   localparam int unsigned FW = (LEN > 2) ? $clog2(LEN) : 1;

   logic [LEN-2:0] hist;     // newest accepted bit in bit 0
   logic [FW-1:0]  fill;     // number of valid bits in hist
   logic [LEN-1:0] window;   // candidate pattern: history plus current bit
   logic           full;
   logic           match;

   assign window = {hist, x};
   assign full   = (fill == FW'(LEN-1));

   // A match needs LEN accepted bits since reset/clr (or since the previous
   // match in non-overlapping mode); clr suppresses a completing pattern.
   assign match  = en & ~clr & full & (window == PATTERN);

   // History and fill only advance on accepted bits, so en=0 gaps are
   // transparent to a partially received pattern.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hist <= '0;
         fill <= '0;
      end else if (clr) begin
         hist <= '0;
         fill <= '0;
      end else if (en) begin
         hist <= window[LEN-2:0];
         if (match && !OVERLAP) begin
            fill <= '0;
         end else if (!full) begin
            fill <= fill + 1'b1;
         end
      end
   end

   // Saturating counter: holds at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         match_cnt <= '0;
      end else if (clr) begin
         match_cnt <= '0;
      end else if (match && (match_cnt != '1)) begin
         match_cnt <= match_cnt + 1'b1;
      end
   end

   generate
      if (MOORE) begin : g_moore
         logic z_q;
         // match is already 0 under clr or en=0, so z_q drops on those edges.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               z_q <= 1'b0;
            end else begin
               z_q <= match;
            end
         end
         assign z = z_q;
      end else begin : g_mealy
         // hist/fill are cleared asynchronously, so z is 0 while rst=0.
         assign z = match;
      end
   endgenerate

endmodule
